// File: rtl/cp0_register_file_pkg.sv
// Shared CP0 constants: register numbers, field positions, implemented-bit masks.
package cp0_register_file_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned INT_W  = 6;

  localparam logic [ADDR_W-1:0] REG_SR    = 5'd12;
  localparam logic [ADDR_W-1:0] REG_CAUSE = 5'd13;
  localparam logic [ADDR_W-1:0] REG_EPC   = 5'd14;
  localparam logic [ADDR_W-1:0] REG_PRID  = 5'd15;

  localparam int unsigned SR_IE_BIT    = 0;
  localparam int unsigned SR_EXL_BIT   = 1;
  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_BD_BIT = 31;

  // Bits that software writes can actually set; IP is owned by hardware.
  localparam logic [DATA_W-1:0] SR_MASK =
    (32'h0000_003F << SR_IM_LO) | (32'd1 << SR_EXL_BIT) | (32'd1 << SR_IE_BIT);
  localparam logic [DATA_W-1:0] CAUSE_WR_MASK =
    (32'd1 << CAUSE_BD_BIT) | (32'h0000_001F << CAUSE_EXC_LO);
  localparam logic [DATA_W-1:0] EPC_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] cause;
    logic [DATA_W-1:0] epc;
  } cp0_regs_t;

endpackage

// File: rtl/cp0_register_file_int_synchronizer.sv
// Two-flop synchronizer for asynchronous interrupt lines.
module int_synchronizer #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  assign dout = sync;

endmodule

// File: rtl/cp0_register_file.sv
// CP0 SR/Cause/EPC register bank with synchronized interrupt pending bits and mfc0 read mux.
module cp0_register_file
  import cp0_register_file_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_5234
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INT_W-1:0]  hw_int,
  input  logic [DATA_W-1:0] new_SR,
  input  logic              SR_enable,
  input  logic [DATA_W-1:0] new_Cause,
  input  logic              Cause_enable,
  input  logic [DATA_W-1:0] new_EPC,
  input  logic              EPC_enable,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] current_SR,
  output logic [DATA_W-1:0] current_Cause,
  output logic [DATA_W-1:0] current_EPC,
  output logic [INT_W-1:0]  interrupt_request
);

  cp0_regs_t        regs;
  logic [INT_W-1:0] ip;

  // The synchronizer's second stage is the IP field storage itself.
  int_synchronizer #(.WIDTH(INT_W)) u_int_sync (
    .clk  (clk),
    .reset(reset),
    .din  (hw_int),
    .dout (ip)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else begin
      if (SR_enable)    regs.sr    <= new_SR & SR_MASK;
      if (Cause_enable) regs.cause <= new_Cause & CAUSE_WR_MASK;
      if (EPC_enable)   regs.epc   <= new_EPC & EPC_MASK;
    end
  end

  assign current_SR        = regs.sr;
  assign current_Cause     = regs.cause | (DATA_W'(ip) << CAUSE_IP_LO);
  assign current_EPC       = regs.epc;
  assign interrupt_request = current_Cause[CAUSE_IP_HI:CAUSE_IP_LO];

  // mfc0 read: no bypass, so a same-cycle write is not visible yet.
  always_comb begin
    read_data = '0;
    case (read_addr)
      REG_SR:    read_data = current_SR;
      REG_CAUSE: read_data = current_Cause;
      REG_EPC:   read_data = current_EPC;
      REG_PRID:  read_data = PRID;
      default:   read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_register_file.sv
// Directed self-checking bench for cp0_register_file.
module tb_cp0_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hw_int;
  logic [31:0] new_SR, new_Cause, new_EPC;
  logic        SR_enable, Cause_enable, EPC_enable;
  logic [4:0]  read_addr;
  logic [31:0] read_data, current_SR, current_Cause, current_EPC;
  logic [5:0]  interrupt_request;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cp0_register_file dut (
    .clk              (clk),
    .reset            (reset),
    .hw_int           (hw_int),
    .new_SR           (new_SR),
    .SR_enable        (SR_enable),
    .new_Cause        (new_Cause),
    .Cause_enable     (Cause_enable),
    .new_EPC          (new_EPC),
    .EPC_enable       (EPC_enable),
    .read_addr        (read_addr),
    .read_data        (read_data),
    .current_SR       (current_SR),
    .current_Cause    (current_Cause),
    .current_EPC      (current_EPC),
    .interrupt_request(interrupt_request)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    read_addr = addr;
    #1;
    check(tag, read_data, exp);
  endtask

  initial begin
    reset = 1'b1; hw_int = '0;
    new_SR = '0; new_Cause = '0; new_EPC = '0;
    SR_enable = 1'b0; Cause_enable = 1'b0; EPC_enable = 1'b0;
    read_addr = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_sr",    current_SR, 32'h0);
    check("rst_cause", current_Cause, 32'h0);
    check("rst_epc",   current_EPC, 32'h0);
    check("rst_irq",   {26'b0, interrupt_request}, 32'h0);
    rd("rst_rd12", 5'd12, 32'h0);
    rd("rst_rd13", 5'd13, 32'h0);
    rd("rst_rd14", 5'd14, 32'h0);
    rd("rst_rd15", 5'd15, 32'h0000_5234);
    rd("rst_rd7",  5'd7,  32'h0);

    // SR write: only IM/EXL/IE survive, no same-cycle bypass
    @(negedge clk);
    new_SR = 32'hFFFF_FFFF; SR_enable = 1'b1;
    rd("sr_wr_cycle_rd", 5'd12, 32'h0);
    @(negedge clk);
    SR_enable = 1'b0; new_SR = 32'h0;
    check("sr_masked", current_SR, 32'h0000_FC03);
    rd("sr_rd12", 5'd12, 32'h0000_FC03);
    rd("rd11_zero", 5'd11, 32'h0);
    rd("rd16_zero", 5'd16, 32'h0);

    // Simultaneous EPC + Cause writes; Cause IP bits ignored
    new_EPC = 32'h0000_3007; EPC_enable = 1'b1;
    new_Cause = 32'h8000_FC28; Cause_enable = 1'b1;
    @(negedge clk);
    EPC_enable = 1'b0; Cause_enable = 1'b0;
    new_EPC = 32'hDEAD_BEEF; new_Cause = 32'hFFFF_FFFF;
    check("epc_wr",   current_EPC, 32'h0000_3004);
    check("cause_wr", current_Cause, 32'h8000_0028);
    check("sr_kept",  current_SR, 32'h0000_FC03);

    // Hold with enables low
    @(negedge clk); @(negedge clk);
    check("hold_sr",    current_SR, 32'h0000_FC03);
    check("hold_cause", current_Cause, 32'h8000_0028);
    check("hold_epc",   current_EPC, 32'h0000_3004);

    // Interrupt latency: exactly two edges each way
    hw_int = 6'b000100;
    @(negedge clk);
    check("irq_1edge", {26'b0, interrupt_request}, 32'h0);
    @(negedge clk);
    check("irq_2edge", {26'b0, interrupt_request}, 32'h0000_0004);
    check("cause_ip12", current_Cause, 32'h8000_1028);
    rd("rd13_ip", 5'd13, 32'h8000_1028);
    hw_int = 6'b000000;
    @(negedge clk);
    check("irq_clr_1edge", {26'b0, interrupt_request}, 32'h0000_0004);
    @(negedge clk);
    check("irq_clr_2edge", {26'b0, interrupt_request}, 32'h0);

    // Cause write with IP field zero must keep hardware IP
    hw_int = 6'b100000;
    @(negedge clk); @(negedge clk);
    check("irq_b5", {26'b0, interrupt_request}, 32'h0000_0020);
    new_Cause = 32'h0000_0014; Cause_enable = 1'b1;
    @(negedge clk);
    Cause_enable = 1'b0;
    check("cause_ip_kept", current_Cause, 32'h0000_8014);

    // Reset beats writes and flushes the synchronizer
    hw_int = 6'b111111;
    @(negedge clk); @(negedge clk);
    check("irq_all", {26'b0, interrupt_request}, 32'h0000_003F);
    reset = 1'b1;
    new_SR = 32'hFFFF_FFFF; SR_enable = 1'b1;
    new_EPC = 32'h1234_5678; EPC_enable = 1'b1;
    @(negedge clk);
    reset = 1'b0; SR_enable = 1'b0; EPC_enable = 1'b0;
    check("rst2_sr",    current_SR, 32'h0);
    check("rst2_cause", current_Cause, 32'h0);
    check("rst2_epc",   current_EPC, 32'h0);
    check("rst2_irq",   {26'b0, interrupt_request}, 32'h0);
    rd("rst2_rd15", 5'd15, 32'h0000_5234);
    rd("rst2_rd12", 5'd12, 32'h0);
    @(negedge clk);
    check("rst2_irq_1edge", {26'b0, interrupt_request}, 32'h0);
    @(negedge clk);
    check("rst2_irq_2edge", {26'b0, interrupt_request}, 32'h0000_003F);
    check("rst2_cause_ip",  current_Cause, 32'h0000_FC00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_register_file.md
CP0_REGISTER_FILE -- requirements
Module: cp0_register_file

Interface
REQ-001 Parameter: PRID, default 32'h0000_5234, constant value returned for CP0 register 15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: hw_int  input  6  raw asynchronous hardware interrupt lines, bit i maps to Cause.IP[10+i].
REQ-005 Port: new_SR / SR_enable  input  32 / 1  SR write data and write strobe.
REQ-006 Port: new_Cause / Cause_enable  input  32 / 1  Cause write data and write strobe.
REQ-007 Port: new_EPC / EPC_enable  input  32 / 1  EPC write data and write strobe.
REQ-008 Port: read_addr  input  5  CP0 register number for mfc0 read.
REQ-009 Port: read_data  output  32  mfc0 read result.
REQ-010 Port: current_SR, current_Cause, current_EPC  output  32 each  registered state, masked per REQ-012..014.
REQ-011 Port: interrupt_request  output  6  synchronized interrupt lines, equal to current_Cause[15:10].

Function
REQ-012 SR implemented bits: IM[15:10], EXL[1], IE[0]; all other bits stored as 0 and read as 0 regardless of write data.
REQ-013 Cause implemented bits: BD[31], ExcCode[6:2] writable; IP[15:10] hardware-owned; all other bits read 0.
REQ-014 EPC: bits [31:2] writable, bits [1:0] forced to 0 on every write.
REQ-015 Each enabled write takes effect at the rising edge ending the cycle in which its enable is high; outputs reflect the new value from the following cycle.
REQ-016 Multiple enables in one cycle: all enabled registers update at the same edge, independently.
REQ-017 hw_int passes a two-flop synchronizer; IP[15:10] loads the second flop output every cycle; latency from hw_int change to interrupt_request change is exactly 2 edges.
REQ-018 Cause write with Cause_enable high never alters IP; IP bits of new_Cause ignored.
REQ-019 read_data combinational from read_addr: 12 -> current_SR, 13 -> current_Cause, 14 -> current_EPC, 15 -> PRID, any other address -> 32'h0.
REQ-020 No write-to-read bypass: a read in the same cycle as a write to the same register returns the pre-write value.
REQ-021 No enable asserted: SR, Cause (except IP), EPC hold value indefinitely.

Reset
REQ-022 reset high at an edge: SR, Cause, EPC, both synchronizer stages cleared to 0; takes priority over every write enable in the same cycle.
REQ-023 All outputs 0 during the cycle after reset except read_data at address 15 (PRID).
REQ-024 Reset mid-operation discards any pending synchronizer contents; IP reflects hw_int again only 2 edges after reset deasserts.

Structure
REQ-025 Register numbers (12, 13, 14, 15) and field bit positions (IM, EXL, IE, BD, IP, ExcCode) defined as constants in the shared utility macros file, alongside existing opcode/ExcCode definitions.
REQ-026 Synchronizer implemented as sub-module int_synchronizer (parameterized width, default 6); register bank and read mux inline.

Verification
REQ-027 Reset, then read_addr 12/13/14/15 -> 0, 0, 0, 32'h0000_5234; read_addr 7 -> 0.
REQ-028 new_SR=32'hFFFF_FFFF, SR_enable=1 one cycle -> current_SR=32'h0000_FC03 next cycle; read at addr 12 in write cycle still 0.
REQ-029 new_EPC=32'h0000_3007, EPC_enable=1 with simultaneous Cause_enable=1, new_Cause=32'h8000_FC28 -> EPC=32'h0000_3004, Cause=32'h8000_0028 (IP=0) same edge.
REQ-030 hw_int 6'b000100 asserted at edge N -> interrupt_request=6'b000100 and Cause[12]=1 from edge N+2, not before; deassert -> clears 2 edges later.
REQ-031 hw_int=6'b111111 held, reset pulsed one cycle alongside SR_enable=1 -> all registers 0 after reset edge; IP returns to 6'b111111 exactly 2 edges after reset low.
REQ-032 Cause_enable=1 with new_Cause[15:10]=6'b000000 while hw_int=6'b100000 stable -> Cause[15]=1 retained after write.
